// File: rtl/cpu_bus_interconnect_if.sv
// CPU-side and device-side bus of the CPU interconnect.
//   cpu_* : single outstanding CPU access (request strobe, completion strobe)
//   dev_* : shared latched request fields, one-hot request and per-slot ack/rdata
// Modports:
//   master : CPU plus peripheral slots (drives the requests, sees the responses)
//   slave  : the interconnect
interface cpu_bus_interconnect_if #(
  parameter int NUM_DEVICES = 8,
  parameter int ADDR_W      = 32
);
  logic                      cpu_request;
  logic [3:0]                cpu_wmask;
  logic [ADDR_W-1:0]         cpu_address;
  logic [31:0]               cpu_wdata;
  logic                      cpu_ack;
  logic                      cpu_error;
  logic [31:0]               cpu_rdata;
  logic [NUM_DEVICES-1:0]    dev_request;
  logic [3:0]                dev_wmask;
  logic [ADDR_W-1:0]         dev_address;
  logic [31:0]               dev_wdata;
  logic [NUM_DEVICES-1:0]    dev_ack;
  logic [NUM_DEVICES*32-1:0] dev_rdata;

  modport master (
    output cpu_request, cpu_wmask, cpu_address, cpu_wdata,
    input  cpu_ack, cpu_error, cpu_rdata,
    input  dev_request, dev_wmask, dev_address, dev_wdata,
    output dev_ack, dev_rdata
  );

  modport slave (
    input  cpu_request, cpu_wmask, cpu_address, cpu_wdata,
    output cpu_ack, cpu_error, cpu_rdata,
    output dev_request, dev_wmask, dev_address, dev_wdata,
    input  dev_ack, dev_rdata
  );
endinterface

// File: rtl/cpu_bus_interconnect.sv
// CPU bus interconnect: routes one CPU access at a time to the device slot
// addressed by the top SEL_W address bits, registers the slot response, and
// answers with a bus error on out-of-range slots or when no ack arrives within
// TIMEOUT cycles of dev_request. Keeps a saturating error count and the
// address of the last failed access.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : cpu_bus_interconnect_if.slave (CPU and device buses)
//   err_clear   : pulse, clears err_count
//   err_count   : saturating count of error responses
//   err_address : address of the most recent error response
//
// state | meaning
// IDLE  | waiting for cpu_request; latches the access
// ISSUE | dev_request pulse to the selected slot
// WAIT  | waiting for the slot ack, timeout running
// RESP  | cpu_ack pulse with error/rdata
module cpu_bus_interconnect #(
  parameter int NUM_DEVICES = 8,
  parameter int ADDR_W      = 32,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_bus_interconnect_if.slave bus,
  input  logic                  err_clear,
  output logic [7:0]            err_count,
  output logic [ADDR_W-1:0]     err_address
);
  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       cpu_idx;
  logic                   cpu_in_range;
  logic [SEL_W-1:0]       idx_q;
  logic [3:0]             wmask_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [31:0]            wdata_q;
  // Counts down the remaining WAIT cycles; zero is the last cycle an ack is accepted.
  logic [TIMER_W-1:0]     timer_q;
  logic                   sel_ack;
  logic [31:0]            sel_rdata;
  logic [NUM_DEVICES-1:0] dev_req_q, dev_req_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [7:0]             err_count_q;
  logic [ADDR_W-1:0]      err_addr_q;

  assign cpu_idx      = bus.cpu_address[ADDR_W-1 -: SEL_W];
  assign cpu_in_range = int'(cpu_idx) < NUM_DEVICES;

  // Ack/rdata of the latched slot only; all other slots are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_ack   = bus.dev_ack[i];
        sel_rdata = bus.dev_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cpu_request) state_d = cpu_in_range ? ISSUE : RESP;
      ISSUE:   state_d = sel_ack ? RESP : WAIT;
      WAIT:    if (sel_ack || timer_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    dev_req_d = '0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    case (state_d)
      ISSUE: begin
        for (int i = 0; i < NUM_DEVICES; i++) dev_req_d[i] = (cpu_idx == SEL_W'(i));
      end
      RESP: begin
        ack_d   = 1'b1;
        // Entering RESP straight from IDLE means an out-of-range slot.
        err_d   = (state_q == IDLE) || !sel_ack;
        rdata_d = ((state_q != IDLE) && sel_ack) ? sel_rdata : 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dev_req_q   <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      idx_q       <= '0;
      wmask_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timer_q     <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      dev_req_q <= dev_req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;

      if (state_q == IDLE && bus.cpu_request) begin
        idx_q   <= cpu_idx;
        wmask_q <= bus.cpu_wmask;
        addr_q  <= bus.cpu_address;
        wdata_q <= bus.cpu_wdata;
      end

      if (state_q == ISSUE)
        timer_q <= TIMER_W'(TIMEOUT - 2);
      else if (state_q == WAIT && timer_q != '0)
        timer_q <= timer_q - TIMER_W'(1);

      // ack_q && err_q marks the error RESP cycle; a coincident clear keeps that error.
      if (err_clear)
        err_count_q <= (ack_q && err_q) ? 8'd1 : 8'd0;
      else if (ack_q && err_q && err_count_q != 8'hFF)
        err_count_q <= err_count_q + 8'd1;

      if (ack_q && err_q) err_addr_q <= addr_q;
    end
  end

  assign bus.dev_request = dev_req_q;
  assign bus.cpu_ack     = ack_q;
  assign bus.cpu_error   = err_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.dev_wmask   = wmask_q;
  assign bus.dev_address = addr_q;
  assign bus.dev_wdata   = wdata_q;
  assign err_count       = err_count_q;
  assign err_address     = err_addr_q;
endmodule

// File: tb/tb_cpu_bus_interconnect.sv
module tb_cpu_bus_interconnect;
  localparam int NDEV = 8;
  localparam int AW   = 32;
  localparam int SW   = 4;
  localparam int TO   = 16;
  localparam int WIN  = TO + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        err_clear = 1'b0;
  logic [7:0]  err_count;
  logic [31:0] err_address;

  cpu_bus_interconnect_if #(.NUM_DEVICES(NDEV), .ADDR_W(AW)) bus();

  cpu_bus_interconnect #(.NUM_DEVICES(NDEV), .ADDR_W(AW), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .err_clear(err_clear),
    .err_count(err_count),
    .err_address(err_address)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One access: d = ack delay in cycles after the dev_request cycle (-1: never).
  // A stray cpu_request with different fields is pushed while the access is busy.
  task automatic access(input string name, input logic [31:0] addr, input logic [3:0] wmask,
                        input logic [31:0] wdata, input logic [31:0] data, input int d,
                        input int spur_slot, input int spur_cyc, input bit clear);
    int          idx;
    bit          in_range;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_vec;
    int          n_ack, ack_cyc, n_req;
    logic        o_err;
    logic [31:0] o_rdata, o_daddr, o_dwdata;
    logic [3:0]  o_dwmask;
    logic [7:0]  o_vec;

    idx      = int'(addr[31:28]);
    in_range = idx < NDEV;
    if (!in_range) begin
      exp_lat = 1; exp_err = 1'b1; exp_rdata = '0;
    end else if (d >= 0 && d <= TO - 1) begin
      exp_lat = d + 2; exp_err = 1'b0; exp_rdata = data;
    end else begin
      exp_lat = TO + 1; exp_err = 1'b1; exp_rdata = '0;
    end
    exp_vec = in_range ? 8'(1 << idx) : 8'h00;

    n_ack = 0; ack_cyc = -1; n_req = 0; o_err = 1'b0; o_rdata = '0; o_vec = '0;
    o_daddr = '0; o_dwdata = '0; o_dwmask = '0;

    for (int i = 0; i < NDEV; i++) bus.dev_rdata[32*i +: 32] = $urandom;
    if (in_range) bus.dev_rdata[32*idx +: 32] = data;

    for (int c = 0; c < WIN; c++) begin
      @(posedge clk); #1;
      bus.cpu_request = (c == 0) || (c == 1 && exp_lat >= 2);
      bus.cpu_address = (c == 1) ? ~addr : addr;
      bus.cpu_wdata   = (c == 1) ? ~wdata : wdata;
      bus.cpu_wmask   = (c == 1) ? ~wmask : wmask;
      bus.dev_ack     = '0;
      if (in_range && d >= 0 && c == d + 1) bus.dev_ack[idx] = 1'b1;
      if (spur_slot >= 0 && c == spur_cyc) bus.dev_ack[spur_slot] = 1'b1;
      err_clear = clear && (c == exp_lat);
      @(negedge clk);
      if (bus.cpu_ack) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc = c; o_err = bus.cpu_error; o_rdata = bus.cpu_rdata;
        end
      end
      if (bus.dev_request != '0) begin
        n_req++;
        o_vec = o_vec | bus.dev_request;
      end
      if (c == WIN - 1) begin
        o_daddr = bus.dev_address; o_dwdata = bus.dev_wdata; o_dwmask = bus.dev_wmask;
      end
    end
    bus.cpu_request = 1'b0;
    bus.dev_ack     = '0;
    err_clear       = 1'b0;

    if (clear) m_cnt = exp_err ? 1 : 0;
    else if (exp_err && m_cnt < 255) m_cnt++;
    if (exp_err) m_addr = addr;

    check({name, ".ack_count"}, n_ack, 1);
    check({name, ".ack_cycle"}, ack_cyc, exp_lat);
    check({name, ".cpu_error"}, o_err, exp_err);
    check({name, ".cpu_rdata"}, o_rdata, exp_rdata);
    check({name, ".req_cycles"}, n_req, in_range ? 1 : 0);
    check({name, ".req_vec"}, o_vec, exp_vec);
    check({name, ".dev_address"}, o_daddr, addr);
    check({name, ".dev_wdata"}, o_dwdata, wdata);
    check({name, ".dev_wmask"}, o_dwmask, wmask);
    check({name, ".err_count"}, err_count, m_cnt);
    check({name, ".err_address"}, err_address, m_addr);
  endtask

  initial begin
    int          ridx, r, sp, acks;
    logic [31:0] a;

    bus.cpu_request = 1'b0;
    bus.cpu_wmask   = '0;
    bus.cpu_address = '0;
    bus.cpu_wdata   = '0;
    bus.dev_ack     = '0;
    bus.dev_rdata   = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset.cpu_ack", bus.cpu_ack, 0);
    check("reset.cpu_error", bus.cpu_error, 0);
    check("reset.cpu_rdata", bus.cpu_rdata, 0);
    check("reset.dev_request", bus.dev_request, 0);
    check("reset.dev_address", bus.dev_address, 0);
    check("reset.dev_wdata", bus.dev_wdata, 0);
    check("reset.dev_wmask", bus.dev_wmask, 0);
    check("reset.err_count", err_count, 0);
    check("reset.err_address", err_address, 0);

    access("read2",  32'h2000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 3,  -1, 0, 1'b0);
    access("write0", 32'h0000_0100, 4'hF, 32'h1234_5678, 32'h0BAD_0BAD, 0,  -1, 0, 1'b0);
    access("oor9",   32'h9000_0000, 4'h0, 32'h0,         32'h0,         -1, -1, 0, 1'b0);
    access("tmo5",   32'h5000_0000, 4'h0, 32'h0,         32'h5555_5555, 19, -1, 0, 1'b0);
    access("wrong4", 32'h3000_0008, 4'h0, 32'h0,         32'h3333_3333, 3,  4,  2, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ridx = $urandom_range(0, 9);
      r    = $urandom_range(0, 21);
      sp   = (ridx + 1 + $urandom_range(0, 6)) % NDEV;
      a    = {ridx[3:0], 28'($urandom)};
      access("rand", a, 4'($urandom), $urandom, $urandom, (r == 21) ? -1 : r,
             sp, $urandom_range(0, 21), $urandom_range(0, 7) == 0);
    end

    // Reset while the access to slot 1 is waiting for its ack.
    @(posedge clk); #1;
    bus.cpu_request = 1'b1;
    bus.cpu_address = 32'h1000_0040;
    bus.cpu_wmask   = 4'h3;
    bus.cpu_wdata   = 32'hCAFE_0001;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.cpu_request = 1'b0;
      reset = (c == 5);
      @(negedge clk);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    m_cnt = 0; m_addr = '0;
    check("midrst.cpu_ack", bus.cpu_ack, 0);
    check("midrst.cpu_error", bus.cpu_error, 0);
    check("midrst.cpu_rdata", bus.cpu_rdata, 0);
    check("midrst.dev_request", bus.dev_request, 0);
    check("midrst.dev_address", bus.dev_address, 0);
    check("midrst.dev_wdata", bus.dev_wdata, 0);
    check("midrst.dev_wmask", bus.dev_wmask, 0);
    check("midrst.err_count", err_count, m_cnt);
    check("midrst.err_address", err_address, m_addr);
    acks = 0;
    for (int c = 7; c < 27; c++) begin
      @(posedge clk); #1;
      bus.dev_ack = (c == 7) ? 8'b0000_0010 : 8'b0;
      @(negedge clk);
      if (bus.cpu_ack) acks++;
    end
    bus.dev_ack = '0;
    check("midrst.no_ack", acks, 0);

    for (int k = 0; k < 256; k++)
      access("sat", {4'(8 + $urandom_range(0, 7)), 28'($urandom)}, 4'h0, 32'h0, 32'h0,
             -1, -1, 0, 1'b0);
    check("sat.err_count", err_count, 8'd255);
    access("clr_err", 32'hA000_0000, 4'h0, 32'h0, 32'h0, -1, -1, 0, 1'b1);
    check("clr_err.err_count", err_count, 8'd1);
    access("clr_ok", 32'h1000_0000, 4'h1, 32'h0000_00AA, 32'h7777_7777, 2, -1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_bus_interconnect.md
Name: cpu_bus_interconnect

Overview:
- Parametrised CPU-bus interconnect that replaces the fixed per-ID bus fan-out inside the CPU SoC. It routes one CPU request at a time to one of NUM_DEVICES peripheral slots, selected by the upper address bits.
- It registers the response from the selected slot.
- It adds a per-access timeout and an out-of-range bus-error response, neither of which the current fan-out has.
- It keeps a saturating error counter and records the address of the last failed access, for firmware diagnostics.

Parameters:
- NUM_DEVICES, 8, number of device slots; valid range 1..2**SEL_W.
- ADDR_W, 32, CPU address width.
- SEL_W, 4, number of address MSBs used as the slot index: idx = address[ADDR_W-1 -: SEL_W].
- TIMEOUT, 256, cycles allowed for a device ack, counted from the dev_request cycle; must be at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_request  in  1  single-cycle access strobe.
- cpu_wmask  in  4  byte write mask; 0 means read.
- cpu_address  in  ADDR_W  access address.
- cpu_wdata  in  32  write data.
- cpu_ack  out  1  single-cycle completion strobe.
- cpu_error  out  1  valid with cpu_ack; 1 means bus error.
- cpu_rdata  out  32  read data; valid with cpu_ack.
- dev_request  out  NUM_DEVICES  one-hot, single-cycle strobe to the selected slot.
- dev_wmask  out  4  latched wmask, shared by all slots.
- dev_address  out  ADDR_W  latched address, shared by all slots.
- dev_wdata  out  32  latched wdata, shared by all slots.
- dev_ack  in  NUM_DEVICES  per-slot ack strobes.
- dev_rdata  in  NUM_DEVICES*32  per-slot read data; slot i occupies bits [32*i+31:32*i].
- err_clear  in  1  single-cycle pulse; clears err_count.
- err_count  out  8  saturating count of error responses.
- err_address  out  ADDR_W  address of the most recent error response.

Behaviour:
- Reset: FSM goes to IDLE. All of the following are cleared to 0: dev_request, cpu_ack, cpu_error, cpu_rdata, dev_wmask, dev_address, dev_wdata, err_count, err_address, and the timer. Reset during any state aborts the access and no cpu_ack is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, on cpu_request:
  - Latch wmask, address, wdata and idx into the dev_* registers and the internal idx.
  - If idx >= NUM_DEVICES, go to RESP with error=1.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - dev_request[idx]=1; timer=1.
  - If dev_ack[idx]=1 in this cycle, go to RESP with error=0 and capture rdata from the idx slot. Otherwise go to WAIT.
- WAIT:
  - If dev_ack[idx]=1, go to RESP with error=0 and capture that slot's rdata.
  - Else if timer == TIMEOUT-1, go to RESP with error=1.
  - Else timer += 1.
- RESP (1 cycle): cpu_ack=1; cpu_error=error; cpu_rdata = captured data, or 0x00000000 when error=1. Next state is IDLE.
- Latency: a cpu_request in cycle 0 gives dev_request in cycle 1. An ack in cycle n≥1 gives cpu_ack in cycle n+1. Minimum request-to-ack latency is 2 cycles.
- Timeout with no ack: cpu_ack+error in cycle TIMEOUT+1 after the request.
- Out-of-range index: cpu_ack+error in cycle 1, and no dev_request is issued.
- Ignored inputs:
  - dev_ack from any slot other than idx.
  - Any dev_ack while in IDLE or RESP.
  - cpu_request outside IDLE (the CPU has a single outstanding access).
- Late ack after a timeout: silently dropped. A late ack from the same slot during a later access to that slot is accepted. This is a documented limitation; devices must not ack after TIMEOUT.
- dev_wmask, dev_address and dev_wdata hold their values from latch until the next accepted cpu_request.
- Errors:
  - On every RESP with error=1: err_address = latched address, and err_count += 1, saturating at 255.
  - err_clear sets err_count to 0.
  - If err_clear coincides with an error RESP, err_count = 1.
- cpu_ack, cpu_error and dev_request are registered outputs with no combinational input-to-output paths.

Test Plan:
- Read, slot 2 acks 3 cycles after dev_request with dev_rdata slice 2 = 0xDEADBEEF, address 0x20000010, wmask 0 → dev_request=0b00000100 for exactly one cycle; cpu_ack 5 cycles after cpu_request; cpu_error=0; cpu_rdata=0xDEADBEEF.
- Write, slot 0 acks in the ISSUE cycle, wmask 0xF, wdata 0x12345678 → dev_wdata=0x12345678; cpu_ack 2 cycles after request; cpu_error=0; err_count stays 0.
- Access to address 0x90000000 with NUM_DEVICES=8 (idx 9) → no dev_request; cpu_ack+error in cycle 1; cpu_rdata=0; err_count=1; err_address=0x90000000.
- TIMEOUT=16, slot 5 never acks → cpu_ack+error in cycle 17; a dev_ack[5] pulse in cycle 20 is ignored and produces no cpu_ack.
- Slot 3 selected, dev_ack[4] pulses in cycle 2, then dev_ack[3] in cycle 4 → only the slot-3 ack completes the access; cpu_ack in cycle 5 with slot-3 data.
- Two further tests:
  - Reset mid-operation: reset asserted in WAIT → no cpu_ack; all outputs 0 next cycle.
  - Saturation and clear: 256 consecutive errors → err_count=255. err_clear coincident with an error → err_count=1.
